// File: rtl/apb_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin APB master arbiter.
package apb_rr_arbiter_pkg;

    localparam int APB_W = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SETUP  = ST_SETUP,
        ACCESS = ST_ACCESS
    } apb_state_e;

    // Wait counter must stick at full scale rather than wrap.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/apb_rr_arbiter_rr_pick.sv
// Combinational round-robin selector: first active request at or after
// (last_idx_i + 1) mod NREQ wins.
module rr_pick
    import apb_rr_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] last_idx_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            sum = {1'b0, last_idx_i} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NREQ)) begin
                sum = sum - (IDX_W+1)'(NREQ);
            end
            cand = sum[IDX_W-1:0];
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB master port between NREQ requesters.
//
//   state  | meaning
//   IDLE   | no transfer; arbitrate and latch winner's addr/wdata/we
//   SETUP  | APB setup phase, psel=1 penable=0, exactly one cycle
//   ACCESS | penable=1; complete on pready or wait-counter timeout
module apb_rr_arbiter
    import apb_rr_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic [NREQ-1:0]         i_req,
    input  logic [NREQ*APB_W-1:0]   i_addr,
    input  logic [NREQ*APB_W-1:0]   i_wdata,
    input  logic [NREQ-1:0]         i_we,
    output logic [NREQ-1:0]         o_gnt,
    output logic [NREQ-1:0]         o_done,
    output logic                    o_err,
    output logic [APB_W-1:0]        o_rdata,
    output logic [APB_W-1:0]        o_paddr,
    output logic [APB_W-1:0]        o_pwdata,
    output logic                    o_psel,
    output logic                    o_penable,
    output logic                    o_pwrite,
    input  logic                    i_pready,
    input  logic                    i_pslverr,
    input  logic [APB_W-1:0]        i_prdata
);

    localparam int IDX_W = $clog2(NREQ);

    apb_state_e       state_q,   state_d;
    logic [NREQ-1:0]  gnt_q,     gnt_d;
    logic [IDX_W-1:0] idx_q,     idx_d;
    logic [IDX_W-1:0] last_q,    last_d;
    logic [APB_W-1:0] paddr_q,   paddr_d;
    logic [APB_W-1:0] pwdata_q,  pwdata_d;
    logic             pwrite_q,  pwrite_d;
    logic             psel_q,    psel_d;
    logic             penable_q, penable_d;
    logic [7:0]       wait_q,    wait_d;

    logic             done_w;
    logic             err_w;
    logic [APB_W-1:0] rdata_w;
    logic [7:0]       wait_inc;
    logic             timeout_w;

    logic [APB_W-1:0] addr_arr  [NREQ];
    logic [APB_W-1:0] wdata_arr [NREQ];

    logic [NREQ-1:0]  pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

    for (genvar k = 0; k < NREQ; k++) begin : g_slice
        assign addr_arr[k]  = i_addr[k*APB_W +: APB_W];
        assign wdata_arr[k] = i_wdata[k*APB_W +: APB_W];
    end

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i      (i_req),
        .last_idx_i (last_q),
        .gnt_o      (pick_gnt),
        .idx_o      (pick_idx),
        .valid_o    (pick_valid)
    );

    assign wait_inc  = sat_inc8(wait_q);
    assign timeout_w = !i_pready && (wait_inc == 8'(TIMEOUT));

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        last_d    = last_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        wait_d    = wait_q;
        done_w    = 1'b0;
        err_w     = 1'b0;
        rdata_w   = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d  = SETUP;
                    gnt_d    = pick_gnt;
                    idx_d    = pick_idx;
                    paddr_d  = addr_arr[pick_idx];
                    pwrite_d = i_we[pick_idx];
                    pwdata_d = i_we[pick_idx] ? wdata_arr[pick_idx] : '0;
                    psel_d   = 1'b1;
                    wait_d   = '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (!i_pready) begin
                    wait_d = wait_inc;
                end
                if (i_pready || timeout_w) begin
                    done_w    = 1'b1;
                    err_w     = i_pready ? i_pslverr : 1'b1;
                    rdata_w   = (i_pready && !pwrite_q) ? i_prdata : '0;
                    last_d    = idx_q;
                    state_d   = IDLE;
                    gnt_d     = '0;
                    paddr_d   = '0;
                    pwdata_d  = '0;
                    pwrite_d  = 1'b0;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            idx_q     <= '0;
            last_q    <= IDX_W'(NREQ - 1);
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            wait_q    <= wait_d;
        end
    end

    // Completion is reported in the ACCESS cycle itself; a pending reset
    // suppresses it so an aborted transfer never signals done.
    assign o_done    = (done_w && i_reset_n) ? gnt_q : '0;
    assign o_err     = done_w && i_reset_n && err_w;
    assign o_rdata   = (done_w && i_reset_n) ? rdata_w : '0;
    assign o_gnt     = gnt_q;
    assign o_paddr   = paddr_q;
    assign o_pwdata  = pwdata_q;
    assign o_pwrite  = pwrite_q;
    assign o_psel    = psel_q;
    assign o_penable = penable_q;

endmodule
